// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory bus of the load/store unit.
// The slave modport is the unit's own view; master is the environment side.
interface load_store_unit_if;
    logic        Start;
    logic        IsStore;
    logic [2:0]  func3;
    logic [31:0] Addr;
    logic [31:0] StoreData;
    logic [31:0] LoadData;
    logic        Done;
    logic        Busy;
    logic        Misaligned;
    logic        BusErr;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [3:0]  MemBe;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemAck;

    modport slave (
        input  Start, IsStore, func3, Addr, StoreData, MemRData, MemAck,
        output LoadData, Done, Busy, Misaligned, BusErr,
               MemReq, MemWe, MemAddr, MemBe, MemWData
    );

    modport master (
        output Start, IsStore, func3, Addr, StoreData, MemRData, MemAck,
        input  LoadData, Done, Busy, Misaligned, BusErr,
               MemReq, MemWe, MemAddr, MemBe, MemWData
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: alignment check, byte enables, req/ack handshake
// with timeout abort, and sign/zero extension of load data.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, REQ, DONE, ERR, ABORT} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        is_store_q;
    logic [2:0]  func3_q;
    logic [31:0] addr_q, sdata_q, ldata_q;
    logic        done_q, busy_q, mis_q, berr_q;

    logic        accept, bad_acc, req;
    logic [31:0] rshift, ext;
    logic [3:0]  be;
    logic [31:0] wdata;

    assign accept = (state_q == IDLE) && bus.Start;
    assign req    = (state_q == REQ);

    // Legality is judged on the raw inputs so the decision is made in IDLE.
    always_comb begin
        bad_acc = 1'b0;
        case (bus.func3[1:0])
            2'b01:   bad_acc = bus.Addr[0];
            2'b10:   bad_acc = |bus.Addr[1:0];
            2'b11:   bad_acc = 1'b1;
            default: bad_acc = 1'b0;
        endcase
        if (bus.IsStore && bus.func3[2]) bad_acc = 1'b1;
    end

    always_comb begin
        rshift = bus.MemRData >> {addr_q[1:0], 3'b000};
        case (func3_q[1:0])
            2'b00:   ext = func3_q[2] ? {24'b0, rshift[7:0]}
                                      : {{24{rshift[7]}}, rshift[7:0]};
            2'b01:   ext = func3_q[2] ? {16'b0, rshift[15:0]}
                                      : {{16{rshift[15]}}, rshift[15:0]};
            default: ext = bus.MemRData;
        endcase
    end

    always_comb begin
        case (func3_q[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_q[1:0];
                wdata = {4{sdata_q[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << addr_q[1:0];
                wdata = {2{sdata_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = sdata_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d = bad_acc ? ERR : REQ;
                    cnt_d   = 8'd0;
                end
            end
            REQ: begin
                // Ack takes priority over the final timeout cycle.
                if (bus.MemAck)             state_d = DONE;
                else if (cnt_q == TO_LAST)  state_d = ABORT;
                else                        cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            is_store_q <= 1'b0;
            func3_q    <= 3'd0;
            addr_q     <= 32'd0;
            sdata_q    <= 32'd0;
            ldata_q    <= 32'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                is_store_q <= bus.IsStore;
                func3_q    <= bus.func3;
                addr_q     <= bus.Addr;
                sdata_q    <= bus.StoreData;
                ldata_q    <= 32'd0;
            end
            if (req && bus.MemAck && !is_store_q) ldata_q <= ext;
            done_q <= (state_d == DONE) || (state_d == ERR) || (state_d == ABORT);
            busy_q <= (state_d != IDLE);
            mis_q  <= (state_d == ERR);
            berr_q <= (state_d == ABORT);
        end
    end

    assign bus.LoadData   = ldata_q;
    assign bus.Done       = done_q;
    assign bus.Busy       = busy_q;
    assign bus.Misaligned = mis_q;
    assign bus.BusErr     = berr_q;

    assign bus.MemReq   = req;
    assign bus.MemWe    = req && is_store_q;
    assign bus.MemAddr  = req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus.MemBe    = req ? be : 4'd0;
    assign bus.MemWData = (req && is_store_q) ? wdata : 32'd0;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, alignment errors,
// timeout abort, ignored Start pulses and asynchronous reset mid-request.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   reqcnt;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd);
        bus.IsStore   = st;
        bus.func3     = f3;
        bus.Addr      = a;
        bus.StoreData = sd;
        bus.Start     = 1'b1;
        step();
        bus.Start     = 1'b0;
    endtask

    task automatic err_case(input string tag, input logic st, input logic [2:0] f3,
                            input logic [31:0] a);
        start_op(st, f3, a, 32'hDEADBEEF);
        chk({tag, "_done"}, bus.Done, 1'b1);
        chk({tag, "_mis"}, bus.Misaligned, 1'b1);
        chk({tag, "_berr"}, bus.BusErr, 1'b0);
        chk({tag, "_noreq"}, bus.MemReq, 1'b0);
        chk({tag, "_busy"}, bus.Busy, 1'b1);
        step();
        chk({tag, "_done_off"}, bus.Done, 1'b0);
        chk({tag, "_mis_off"}, bus.Misaligned, 1'b0);
        chk({tag, "_idle"}, bus.Busy, 1'b0);
    endtask

    initial begin
        bus.Start = 1'b0; bus.IsStore = 1'b0; bus.func3 = 3'd0;
        bus.Addr = 32'd0; bus.StoreData = 32'd0;
        bus.MemRData = 32'd0; bus.MemAck = 1'b0;

        // Reset state
        step(); step();
        chk("rst_done", bus.Done, 1'b0);
        chk("rst_busy", bus.Busy, 1'b0);
        chk("rst_req", bus.MemReq, 1'b0);
        chk("rst_ldata", bus.LoadData, 32'd0);
        rst_n = 1'b1;
        step();

        // LB 0x1003, ack in first REQ cycle
        start_op(1'b0, 3'b000, 32'h0000_1003, 32'd0);
        chk("lb_req", bus.MemReq, 1'b1);
        chk("lb_addr", bus.MemAddr, 32'h0000_1000);
        chk("lb_be", bus.MemBe, 4'b1000);
        chk("lb_we", bus.MemWe, 1'b0);
        chk("lb_wdata", bus.MemWData, 32'd0);
        chk("lb_busy", bus.Busy, 1'b1);
        chk("lb_nodone", bus.Done, 1'b0);
        bus.MemAck = 1'b1; bus.MemRData = 32'h80FF_EE11;
        step();
        bus.MemAck = 1'b0;
        chk("lb_done", bus.Done, 1'b1);
        chk("lb_ldata", bus.LoadData, 32'hFFFF_FF80);
        chk("lb_flags", {bus.Misaligned, bus.BusErr}, 2'b00);
        chk("lb_req_off", bus.MemReq, 1'b0);
        step();
        chk("lb_done_off", bus.Done, 1'b0);
        chk("lb_busy_off", bus.Busy, 1'b0);
        chk("lb_ldata_hold", bus.LoadData, 32'hFFFF_FF80);

        // LHU 0x2002, ack after 3 wait cycles; Start pulsed during REQ and Done
        start_op(1'b0, 3'b101, 32'h0000_2002, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("lhu_req", bus.MemReq, 1'b1);
            chk("lhu_addr", bus.MemAddr, 32'h0000_2000);
            chk("lhu_be", bus.MemBe, 4'b1100);
            if (i == 1) begin
                bus.IsStore = 1'b1; bus.func3 = 3'b010; bus.Addr = 32'h0000_9000;
                bus.Start = 1'b1;
            end else begin
                bus.Start = 1'b0;
            end
            if (i == 3) begin
                bus.MemAck = 1'b1; bus.MemRData = 32'hBEEF_1234;
            end
            step();
        end
        bus.MemAck = 1'b0;
        chk("lhu_done", bus.Done, 1'b1);
        chk("lhu_ldata", bus.LoadData, 32'h0000_BEEF);
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        chk("start_in_done_ignored", bus.Busy, 1'b0);
        chk("start_in_done_noreq", bus.MemReq, 1'b0);

        // LW timeout: MemReq high exactly 16 cycles then BusErr
        start_op(1'b0, 3'b010, 32'h0000_6000, 32'd0);
        reqcnt = 0;
        for (int i = 0; i < 40 && !bus.Done; i++) begin
            if (bus.MemReq) reqcnt++;
            step();
        end
        chk("to_reqcnt", reqcnt, 32'd16);
        chk("to_done", bus.Done, 1'b1);
        chk("to_berr", bus.BusErr, 1'b1);
        chk("to_mis", bus.Misaligned, 1'b0);
        chk("to_ldata", bus.LoadData, 32'd0);
        step();
        chk("to_berr_off", bus.BusErr, 1'b0);

        // LW with ack on the 16th request cycle completes normally
        start_op(1'b0, 3'b010, 32'h0000_6004, 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk("to16_req", bus.MemReq, 1'b1);
            if (i == 15) begin
                bus.MemAck = 1'b1; bus.MemRData = 32'hCAFE_F00D;
            end
            step();
        end
        bus.MemAck = 1'b0;
        chk("to16_done", bus.Done, 1'b1);
        chk("to16_berr", bus.BusErr, 1'b0);
        chk("to16_ldata", bus.LoadData, 32'hCAFE_F00D);
        step();

        // SB 0x3001
        start_op(1'b1, 3'b000, 32'h0000_3001, 32'h1234_56AB);
        chk("sb_we", bus.MemWe, 1'b1);
        chk("sb_be", bus.MemBe, 4'b0010);
        chk("sb_wdata", bus.MemWData, 32'hABAB_ABAB);
        chk("sb_addr", bus.MemAddr, 32'h0000_3000);
        bus.MemAck = 1'b1; bus.MemRData = 32'hFFFF_FFFF;
        step();
        bus.MemAck = 1'b0;
        chk("sb_done", bus.Done, 1'b1);
        chk("sb_flags", {bus.Misaligned, bus.BusErr}, 2'b00);
        chk("sb_ldata", bus.LoadData, 32'd0);
        step();

        // SH 0x3002 half-lane replication
        start_op(1'b1, 3'b001, 32'h0000_3002, 32'h1234_5678);
        chk("sh_be", bus.MemBe, 4'b1100);
        chk("sh_wdata", bus.MemWData, 32'h5678_5678);
        bus.MemAck = 1'b1;
        step();
        bus.MemAck = 1'b0;
        step();

        // Misaligned / illegal accesses
        err_case("sw_mis", 1'b1, 3'b010, 32'h0000_4002);
        err_case("lh_mis", 1'b0, 3'b001, 32'h0000_4001);
        err_case("f3_011", 1'b0, 3'b011, 32'h0000_5000);
        err_case("sbu_ill", 1'b1, 3'b100, 32'h0000_5000);

        // Asynchronous reset mid-REQ
        start_op(1'b0, 3'b010, 32'h0000_7000, 32'd0);
        chk("rr_req", bus.MemReq, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rr_req_drop", bus.MemReq, 1'b0);
        chk("rr_busy", bus.Busy, 1'b0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rr_idle_done", bus.Done, 1'b0);
        chk("rr_idle_addr", bus.MemAddr, 32'd0);
        chk("rr_idle_ldata", bus.LoadData, 32'd0);
        start_op(1'b0, 3'b100, 32'h0000_7002, 32'd0);
        chk("rr_lbu_req", bus.MemReq, 1'b1);
        chk("rr_lbu_be", bus.MemBe, 4'b0100);
        bus.MemAck = 1'b1; bus.MemRData = 32'h00A5_0000;
        step();
        bus.MemAck = 1'b0;
        chk("rr_lbu_done", bus.Done, 1'b1);
        chk("rr_lbu_ldata", bus.LoadData, 32'h0000_00A5);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
